lsu_bus_if: RTL and testbench

- Load/store unit that sits directly downstream of the core datapath's data-memory port (DmemAddr, DmemDataI, MemWr, MemOp).
- Converts a single core memory request into a valid/ready bus transaction on a 64-bit, 8-byte-aligned data bus.
- Generates byte strobes and lane-shifted write data.
- Returns sign- or zero-extended load data, or an error for misaligned, illegal-op or timed-out accesses.
- Holds the core stalled (req_ready low) while a transaction is outstanding.

---
 rtl/lsu_bus_if.sv | 163 ++++++++++++++++
 tb/tb_lsu_bus_if.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_if.sv
// Load/store unit: turns one core memory request into a 64-bit aligned valid/ready bus transaction.
// Latency: 3 cycles request-to-response on a zero-wait bus; 1 cycle for misaligned/illegal requests.
// Backpressure: req_ready is low from acceptance until DONE; bus fields hold until bus_req_ready.
module lsu_bus_if #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_wr,
  input  logic [2:0]      i_req_op,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_bus_req_valid,
  input  logic            i_bus_req_ready,
  output logic [XLEN-1:0] o_bus_addr,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_wdata,
  output logic [7:0]      o_bus_wstrb,
  input  logic            i_bus_rsp_valid,
  input  logic [XLEN-1:0] i_bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wr;
  logic [2:0]       r_op;
  logic [2:0]       r_lane;

  logic [2:0]       w_lane;
  logic             w_illegal;
  logic             w_misalign;
  logic [7:0]       w_base;
  logic [XLEN-1:0]  w_shifted;
  logic [XLEN-1:0]  w_ext;
  logic             w_tmo;

  // Decode the incoming request: access size, strobe pattern, alignment and legality.
  always_comb begin
    w_lane     = i_req_addr[2:0];
    w_illegal  = (i_req_op == 3'b111) || (i_req_wr && i_req_op[2]);
    w_base     = 8'hFF;
    w_misalign = 1'b0;
    case (i_req_op[1:0])
      2'b00:   begin w_base = 8'h01; w_misalign = 1'b0;               end
      2'b01:   begin w_base = 8'h03; w_misalign = i_req_addr[0];      end
      2'b10:   begin w_base = 8'h0F; w_misalign = |i_req_addr[1:0];  end
      default: begin w_base = 8'hFF; w_misalign = |i_req_addr[2:0];  end
    endcase
  end

  // Pull the addressed lane down to bit 0 and extend it per the captured op; flag the last allowed cycle.
  always_comb begin
    w_shifted = i_bus_rdata >> {r_lane, 3'b000};
    w_ext     = w_shifted;
    case (r_op)
      3'b000:  w_ext = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      3'b001:  w_ext = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_ext = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      3'b100:  w_ext = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
      3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      3'b110:  w_ext = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: w_ext = w_shifted;
    endcase
    w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Transaction FSM with all outputs registered; a response beats a timeout in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_wr            <= 1'b0;
      r_op            <= 3'b000;
      r_lane          <= 3'b000;
      o_req_ready     <= 1'b1;
      o_rsp_valid     <= 1'b0;
      o_rsp_rdata     <= '0;
      o_rsp_err       <= 1'b0;
      o_bus_req_valid <= 1'b0;
      o_bus_addr      <= '0;
      o_bus_we        <= 1'b0;
      o_bus_wdata     <= '0;
      o_bus_wstrb     <= 8'h00;
    end else begin
      o_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_wr        <= i_req_wr;
            r_op        <= i_req_op;
            r_lane      <= w_lane;
            o_req_ready <= 1'b0;
            if (w_illegal || w_misalign) begin
              r_state     <= S_DONE;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= '0;
            end else begin
              r_state         <= S_REQ;
              r_cnt           <= '0;
              o_bus_req_valid <= 1'b1;
              o_bus_addr      <= {i_req_addr[XLEN-1:3], 3'b000};
              o_bus_we        <= i_req_wr;
              o_bus_wdata     <= i_req_wr ? (i_req_wdata << {w_lane, 3'b000}) : '0;
              o_bus_wstrb     <= i_req_wr ? (w_base << w_lane) : 8'h00;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (i_bus_req_ready && i_bus_rsp_valid) begin
            r_state         <= S_DONE;
            o_bus_req_valid <= 1'b0;
            o_rsp_valid     <= 1'b1;
            o_rsp_err       <= 1'b0;
            o_rsp_rdata     <= r_wr ? '0 : w_ext;
          end else if (w_tmo) begin
            r_state         <= S_DONE;
            o_bus_req_valid <= 1'b0;
            o_rsp_valid     <= 1'b1;
            o_rsp_err       <= 1'b1;
            o_rsp_rdata     <= '0;
          end else if (i_bus_req_ready) begin
            r_state         <= S_WAIT;
            o_bus_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (i_bus_rsp_valid) begin
            r_state     <= S_DONE;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= r_wr ? '0 : w_ext;
          end else if (w_tmo) begin
            r_state     <= S_DONE;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_rdata <= '0;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          o_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Scoreboard bench for lsu_bus_if: directed cases plus randomized loads/stores with a random-latency bus.
// Expected bus fields and responses are queued at issue time and checked by an independent monitor.
// Timeout is shortened to 8 cycles so the abort path is cheap to reach.
module tb_lsu_bus_if;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic [63:0] bus_addr;
  logic        bus_we;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rsp_valid = 1'b0;
  logic [63:0] bus_rdata = '0;

  lsu_bus_if #(.XLEN(64), .TIMEOUT(TMO), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
    .i_req_op(req_op), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_bus_req_valid(bus_req_valid), .i_bus_req_ready(bus_req_ready),
    .o_bus_addr(bus_addr), .o_bus_we(bus_we), .o_bus_wdata(bus_wdata),
    .o_bus_wstrb(bus_wstrb), .i_bus_rsp_valid(bus_rsp_valid), .i_bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } bus_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  bus_t mon_b;
  rsp_t mon_r;
  int   n_checks = 0;
  int   n_pass = 0;
  int   lat_seen;
  bit   mon_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference load result: pick the addressed bytes, then extend by size and signedness.
  function automatic logic [63:0] load_model(input logic [2:0] op, input logic [2:0] lane,
                                             input logic [63:0] rd);
    int          sz;
    logic [63:0] mask;
    logic [63:0] v;
    sz   = 1 << op[1:0];
    mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
    v    = (rd >> (8 * lane)) & mask;
    if (!op[2] && sz < 8 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // Monitor: checks bus fields every cycle the request is valid and every response pulse.
  initial begin
    wait (mon_on);
    forever begin
      @(negedge clk);
      if (bus_req_valid === 1'b1) begin
        chk("bus_expected", 64'(exp_bus.size() > 0), 64'd1);
        if (exp_bus.size() > 0) begin
          mon_b = exp_bus[0];
          chk("bus_addr", bus_addr, mon_b.addr);
          chk("bus_we", 64'(bus_we), 64'(mon_b.we));
          chk("bus_wstrb", 64'(bus_wstrb), 64'(mon_b.wstrb));
          if (mon_b.we) chk("bus_wdata", bus_wdata, mon_b.wdata);
          if (bus_req_ready === 1'b1) mon_b = exp_bus.pop_front();
        end
      end
      if (rsp_valid === 1'b1) begin
        chk("rsp_expected", 64'(exp_rsp.size() > 0), 64'd1);
        if (exp_rsp.size() > 0) begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_r.rdata);
          chk("rsp_err", 64'(rsp_err), 64'(mon_r.err));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    for (int k = 0; k < 50 && req_ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    chk("req_ready_seen", 64'(req_ready), 64'd1);
  endtask

  // Bus slave: accept after rdly cycles; respond sdly cycles after the handshake (0 = same cycle).
  task automatic slave_run(input int rdly, input int sdly, input logic [63:0] rd);
    if (rdly >= 0) begin
      repeat (rdly) begin @(posedge clk); #1; end
      bus_req_ready = 1'b1;
      if (sdly == 0) begin bus_rsp_valid = 1'b1; bus_rdata = rd; end
      @(posedge clk); #1;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      if (sdly > 0) begin
        repeat (sdly - 1) begin @(posedge clk); #1; end
        bus_rsp_valid = 1'b1;
        bus_rdata = rd;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
      end
    end
  endtask

  task automatic watch_rsp();
    lat_seen = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat_seen = i;
        break;
      end
    end
  endtask

  // One request; rdly < 0 means the bus never accepts, forcing a timeout.
  task automatic txn(input logic wr, input logic [2:0] op, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [63:0] rd,
                     input int rdly, input int sdly);
    int         sz;
    int         exp_lat;
    bit         bad;
    logic [2:0] lane;
    bus_t       b;
    rsp_t       r;
    sz   = 1 << op[1:0];
    lane = addr[2:0];
    bad  = (op == 3'b111) || (wr && op[2]) || ((int'(lane) % sz) != 0);
    wait_ready();
    req_valid = 1'b1;
    req_wr    = wr;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (bad) begin
      r.rdata = '0; r.err = 1'b1; exp_lat = 1;
    end else begin
      b.addr  = {addr[63:3], 3'b000};
      b.we    = wr;
      b.wdata = wdata << (8 * lane);
      b.wstrb = wr ? 8'(((1 << sz) - 1) << lane) : 8'h00;
      exp_bus.push_back(b);
      if (rdly < 0) begin
        r.rdata = '0; r.err = 1'b1; exp_lat = TMO + 1;
      end else begin
        r.rdata = wr ? 64'd0 : load_model(op, lane, rd);
        r.err   = 1'b0;
        exp_lat = rdly + 2 + sdly;
      end
    end
    exp_rsp.push_back(r);
    fork
      begin if (!bad) slave_run(rdly, sdly, rd); end
      watch_rsp();
    join
    chk("latency", 64'(lat_seen), 64'(exp_lat));
    if (!bad && rdly < 0) begin
      chk("bus_req_valid_after_tmo", 64'(bus_req_valid), 64'd0);
      b = exp_bus.pop_front();
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_bus_req_valid", 64'(bus_req_valid), 64'd0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    chk("rst_bus_we", 64'(bus_we), 64'd0);
    chk("rst_bus_wdata", bus_wdata, 64'd0);
    chk("rst_bus_wstrb", 64'(bus_wstrb), 64'd0);
  endtask

  initial begin
    logic        wr;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] rd;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    mon_on = 1'b1;
    @(posedge clk); #1;

    // Signed byte load, zero-wait bus.
    txn(1'b0, 3'b000, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000, 0, 1);
    // Unsigned word load.
    txn(1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 0, 1);
    // Halfword store with 3-cycle delayed accept.
    txn(1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'd0, 3, 1);
    // Response in the same cycle as the handshake.
    txn(1'b0, 3'b010, 64'h8000_0010, 64'd0, 64'h1234_5678_F000_0001, 1, 0);
    // Misaligned word, illegal op, store with unsigned op.
    txn(1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 1);
    txn(1'b0, 3'b111, 64'h8000_0000, 64'd0, 64'd0, 0, 1);
    txn(1'b1, 3'b100, 64'h8000_0000, 64'h55, 64'd0, 0, 1);
    // Response arriving on the very last allowed cycle still wins.
    txn(1'b0, 3'b001, 64'h8000_0002, 64'd0, 64'h0000_0000_8001_0000, 4, 3);

    // Timeout, then a stale response in IDLE must be ignored.
    txn(1'b0, 3'b011, 64'h8000_0018, 64'd0, 64'd0, -1, 0);
    @(posedge clk); #1;
    bus_rsp_valid = 1'b1;
    bus_rdata = 64'hDEAD_BEEF_0000_1111;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    chk("tmo_err_hold", 64'(rsp_err), 64'd1);
    chk("tmo_rdata_hold", rsp_rdata, 64'd0);
    chk("tmo_idle_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Reset while waiting for a load response.
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b0; req_op = 3'b011;
    req_addr = 64'h8000_0020; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_bus.push_back('{addr: 64'h8000_0020, we: 1'b0, wdata: 64'd0, wstrb: 8'h00});
    slave_run(0, -1, 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    chk("bus_q_after_reset", 64'(exp_bus.size()), 64'd0);
    @(posedge clk); #1;
    bus_rsp_valid = 1'b1;
    bus_rdata = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    txn(1'b0, 3'b011, 64'h8000_0008, 64'd0, 64'hA5A5_0123_4567_89AB, 0, 1);

    // Randomized back-to-back traffic.
    for (int n = 0; n < 150; n++) begin
      wr   = 1'($urandom_range(0, 1));
      op   = 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      rd   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0)
        addr[2:0] = addr[2:0] & ~((3'd1 << op[1:0]) - 3'd1);
      txn(wr, op, addr, {$urandom, $urandom}, rd,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    chk("exp_bus_drained", 64'(exp_bus.size()), 64'd0);
    chk("exp_rsp_drained", 64'(exp_rsp.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
